tcs_color_classifier: RTL and testbench



---
 rtl/tcs_color_classifier.sv | 205 ++++++++++++++++++++
 tb/tb_tcs_color_classifier.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tcs_color_classifier.sv
// tcs_color_classifier: drives the S2/S3 filter selects of a TCS3200-style
// colour sensor and counts its output edges for red, green and blue in turn.
// Each R/G/B frame is classified into a 3-bit colour code, which is published
// only after STABLE_N consecutive identical frames.
// Optional build macro COLOR_HOLD_EN: when defined, a raw NONE classification
// is dropped, so color holds its last real colour.
`timescale 1ns/1ps
module tcs_color_classifier #(
    parameter int WINDOW_CYCLES = 100000,
    parameter int SETTLE_CYCLES = 5000,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 20,
    parameter int STABLE_N      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_out,
    output logic       s2,
    output logic       s3,
    output logic [2:0] color,
    output logic       color_valid,
    output logic       frame_done
);
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STB_W   = $clog2(STABLE_N + 1);
    localparam int CW2     = CNT_W + 2;

    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_FULL = STB_W'(STABLE_N);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CW2-1:0]   MIN_CW2  = CW2'(MIN_COUNT);

    localparam logic [2:0] C_RED    = 3'b000;
    localparam logic [2:0] C_GREEN  = 3'b001;
    localparam logic [2:0] C_BLUE   = 3'b010;
    localparam logic [2:0] C_YELLOW = 3'b011;
    localparam logic [2:0] C_NONE   = 3'b100;

    // {s2,s3} filter encodings; the clear filter (10) is never selected
    localparam logic [1:0] SEL_R = 2'b00;
    localparam logic [1:0] SEL_G = 2'b11;
    localparam logic [1:0] SEL_B = 2'b01;

    // Encoding places channel k's settle/count states at 2k / 2k+1
    typedef enum logic [2:0] {
        SETTLE_R = 3'd0,
        COUNT_R  = 3'd1,
        SETTLE_G = 3'd2,
        COUNT_G  = 3'd3,
        SETTLE_B = 3'd4,
        COUNT_B  = 3'd5,
        CLASSIFY = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        sel_q, sel_d;
    logic              sync1_q, sync2_q;
    logic              rise;
    logic [CNT_W-1:0]  chan_cnt [3];
    logic [2:0]        raw_color;
    logic [2:0]        cand_q, cand_d;
    logic [STB_W-1:0]  stab_q, stab_d;
    logic [2:0]        color_q, color_d;
    logic              valid_q, valid_d;

    // Two-flop synchroniser for the asynchronous sensor square wave
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_out;
            sync2_q <= sync1_q;
        end
    end

    assign rise = sync1_q & ~sync2_q;

    // State, phase timer and filter-select registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SETTLE_R;
            timer_q <= '0;
            sel_q   <= SEL_R;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
        end
    end

    // Sequencer: fixed-length settle and count phases per channel, then one classify cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        sel_d   = sel_q;
        case (state_q)
            SETTLE_R: if (timer_q == SET_LAST) begin state_d = COUNT_R; timer_d = '0; end
            COUNT_R:  if (timer_q == WIN_LAST) begin state_d = SETTLE_G; timer_d = '0; sel_d = SEL_G; end
            SETTLE_G: if (timer_q == SET_LAST) begin state_d = COUNT_G; timer_d = '0; end
            COUNT_G:  if (timer_q == WIN_LAST) begin state_d = SETTLE_B; timer_d = '0; sel_d = SEL_B; end
            SETTLE_B: if (timer_q == SET_LAST) begin state_d = COUNT_B; timer_d = '0; end
            COUNT_B:  if (timer_q == WIN_LAST) begin state_d = CLASSIFY; timer_d = '0; end
            CLASSIFY: begin state_d = SETTLE_R; timer_d = '0; sel_d = SEL_R; end
            default:  begin state_d = SETTLE_R; timer_d = '0; sel_d = SEL_R; end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            localparam state_t ST_SETTLE = state_t'(3'(2 * gi));
            localparam state_t ST_COUNT  = state_t'(3'(2 * gi + 1));
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Clear during this channel's settle; count edges with saturation during its window
            always_comb begin
                cnt_d = cnt_q;
                if (state_q == ST_SETTLE)
                    cnt_d = '0;
                else if (state_q == ST_COUNT && rise && cnt_q != CNT_MAX)
                    cnt_d = cnt_q + 1'b1;
            end

            // Per-channel edge counter register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign chan_cnt[gi] = cnt_q;
        end
    endgenerate

    // Classifier on the frozen counts, widened so 4*min and 3*max cannot overflow
    always_comb begin
        logic [CW2-1:0] r, g, b, min_rg, max_rg, max_all;
        r       = CW2'(chan_cnt[0]);
        g       = CW2'(chan_cnt[1]);
        b       = CW2'(chan_cnt[2]);
        min_rg  = (r < g) ? r : g;
        max_rg  = (r < g) ? g : r;
        max_all = (max_rg > b) ? max_rg : b;
        if (max_all < MIN_CW2)
            raw_color = C_NONE;
        else if ((min_rg > b + (b >> 1)) && ((min_rg << 2) >= (max_rg << 1) + max_rg))
            raw_color = C_YELLOW;
        else if (r >= g && r >= b)
            raw_color = C_RED;
        else if (g >= b)
            raw_color = C_GREEN;
        else
            raw_color = C_BLUE;
    end

    // Debounce: publish a candidate once it has been seen STABLE_N frames in a row
    always_comb begin
        logic take;
        cand_d  = cand_q;
        stab_d  = stab_q;
        color_d = color_q;
        valid_d = 1'b0;
        take    = (state_q == CLASSIFY);
`ifdef COLOR_HOLD_EN
        if (raw_color == C_NONE) take = 1'b0;
`endif
        if (take) begin
            if (raw_color == cand_q) begin
                if (stab_q != STB_FULL) stab_d = stab_q + 1'b1;
            end else begin
                cand_d = raw_color;
                stab_d = STB_W'(1);
            end
            if (stab_d == STB_FULL && cand_d != color_q) begin
                color_d = cand_d;
                valid_d = 1'b1;
            end
        end
    end

    // Debounce and published-colour registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q  <= C_NONE;
            stab_q  <= '0;
            color_q <= C_NONE;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            color_q <= color_d;
            valid_q <= valid_d;
        end
    end

    assign s2          = sel_q[1];
    assign s3          = sel_q[0];
    assign color       = color_q;
    assign color_valid = valid_q;
    assign frame_done  = (state_q == CLASSIFY);

endmodule

// File: tb/tb_tcs_color_classifier.sv
// tb_tcs_color_classifier: table of sensor-period vectors, each run for a
// number of frames and checked for final colour and color_valid pulse count,
// plus hand-written sequences for select timing and mid-frame reset.
`timescale 1ns/1ps
module tb_tcs_color_classifier;
    localparam int WIN   = 200;
    localparam int SET   = 20;
    localparam int CW    = 6;
    localparam int MINC  = 10;
    localparam int SN    = 3;
    localparam int FRAME = 3 * (SET + WIN) + 1;
    localparam int NV    = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor_out = 1'b0;
    logic       s2, s3;
    logic [2:0] color;
    logic       color_valid, frame_done;

    tcs_color_classifier #(
        .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .CNT_W(CW),
        .MIN_COUNT(MINC), .STABLE_N(SN)
    ) dut (
        .clk(clk), .reset(reset), .sensor_out(sensor_out),
        .s2(s2), .s3(s3), .color(color),
        .color_valid(color_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Sensor model: square wave whose period (clk cycles, 0 = constant low) follows the filter
    int per_r = 0, per_g = 0, per_b = 0;
    int ph = 0;
    always @(negedge clk) begin
        int p;
        case ({s2, s3})
            2'b00:   p = per_r;
            2'b11:   p = per_g;
            2'b01:   p = per_b;
            default: p = 0;
        endcase
        if (p == 0) begin
            ph = 0;
            sensor_out = 1'b0;
        end else begin
            ph = (ph + 1 >= p) ? 0 : ph + 1;
            sensor_out = (ph < p / 2);
        end
    end

    int vp_cnt = 0;
    always @(negedge clk) if (color_valid) vp_cnt++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 1000);
        check("frame_done_seen", int'(frame_done), 1);
    endtask

    typedef struct {
        int         pr;
        int         pg;
        int         pb;
        int         nfr;
        logic [2:0] ecol;
        int         epul;
    } vec_t;

    vec_t vecs [NV];

    initial begin
        int n, m, base;

        // Periods -> window counts (200-cycle window): 2->100, 3->66/67, 4->50,
        // 5->40, 7->28/29, 20->10, 40->5, 50->4, 60->3/4
        vecs[0]  = '{4, 20, 20, 3, 3'b000, 1};   // 50/10/10 red
        vecs[1]  = '{4, 5, 20, 3, 3'b011, 1};    // 50/40/10: 40>15, 160>=150 yellow
        vecs[2]  = '{4, 7, 20, 3, 3'b000, 1};    // 50/~28/10: 4*28<150 -> red
        vecs[3]  = '{40, 5, 5, 3, 3'b001, 1};    // 5/40/40 tie -> green
        vecs[4]  = '{0, 0, 5, 1, 3'b001, 0};     // alternating blue/green frames
        vecs[5]  = '{0, 5, 0, 1, 3'b001, 0};
        vecs[6]  = '{0, 0, 5, 1, 3'b001, 0};
        vecs[7]  = '{0, 5, 0, 1, 3'b001, 0};
        vecs[8]  = '{0, 0, 5, 1, 3'b001, 0};
        vecs[9]  = '{0, 5, 0, 1, 3'b001, 0};
        vecs[10] = '{4, 20, 20, 3, 3'b000, 1};   // re-confirm red
`ifdef COLOR_HOLD_EN
        vecs[11] = '{40, 50, 60, 3, 3'b000, 0};  // dark dropped, red held
        vecs[12] = '{3, 5, 0, 3, 3'b000, 0};     // r saturates 63 > g 40, already red
`else
        vecs[11] = '{40, 50, 60, 3, 3'b100, 1};  // dark -> NONE
        vecs[12] = '{3, 5, 0, 3, 3'b000, 1};     // r saturates 63 > g 40 (wrap would give green)
`endif
        vecs[13] = '{2, 0, 0, 3, 3'b000, 0};     // red-only at full toggle rate

        per_r = vecs[0].pr; per_g = vecs[0].pg; per_b = vecs[0].pb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_color", int'(color), 3'b100);
        check("rst_color_valid", int'(color_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_s2", int'(s2), 0);
        check("rst_s3", int'(s3), 0);
        $display("reset: color=%b s2s3=%b%b", color, s2, s3);
        reset = 1'b0;

        // Filter selects switch on entry to SETTLE_G (edge 220) and SETTLE_B (edge 440)
        repeat (219) @(posedge clk);
        #1 check("sel_before_g", int'({s2, s3}), 2'b00);
        @(posedge clk);
        #1 check("sel_green", int'({s2, s3}), 2'b11);
        repeat (220) @(posedge clk);
        #1 check("sel_blue", int'({s2, s3}), 2'b01);
        $display("select sequence: s2s3=%b%b in blue slot", s2, s3);

        for (int i = 0; i < NV; i++) begin
            per_r = vecs[i].pr; per_g = vecs[i].pg; per_b = vecs[i].pb;
            base = vp_cnt;
            for (int f = 0; f < vecs[i].nfr; f++) wait_frame();
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_color", i), int'(color), int'(vecs[i].ecol));
            check($sformatf("vec%0d_pulses", i), vp_cnt - base, vecs[i].epul);
            $display("vec %0d: periods %0d/%0d/%0d frames=%0d color=%b pulses=%0d",
                     i, vecs[i].pr, vecs[i].pg, vecs[i].pb, vecs[i].nfr, color, vp_cnt - base);
        end

        // Reset in the middle of COUNT_G
        n = 0;
        do begin @(negedge clk); n++; end while ({s2, s3} != 2'b11 && n < 1000);
        check("reach_settle_g", int'({s2, s3}), 2'b11);
        repeat (SET + 50) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_color", int'(color), 3'b100);
        check("midrst_s2", int'(s2), 0);
        check("midrst_s3", int'(s3), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Cycle 1 runs from release to the first edge; CLASSIFY must be cycle FRAME
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!frame_done && n < 2000);
        check("first_frame_done_cycle", n + 1, FRAME);
        check("color_after_1_frame", int'(color), 3'b100);
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!frame_done && m < 2000);
        check("frame_period", m, FRAME);
        check("color_after_2_frames", int'(color), 3'b100);
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!frame_done && m < 2000);
        check("frame_period_2", m, FRAME);
        @(posedge clk);
        #1;
        check("color_after_3_frames", int'(color), 3'b000);
        check("valid_after_3_frames", int'(color_valid), 1);
        $display("mid-frame reset: first frame_done at cycle %0d, color=%b", n + 1, color);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
